alu_result_checker: RTL and testbench

//   Monitor/responder on the ALU operand/result interface. Samples each (input_1, input_2,
//   alu_control, alu_result) transaction, recomputes the expected result in a 2-stage

---
 rtl/alu_result_checker.sv | 145 ++++++++++++++
 tb/tb_alu_result_checker.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/alu_result_checker.sv
// rtl/alu_result_checker.sv - ALU result checker: 2-stage recompute, saturating pass/fail counts, first-fail capture.
// Optional macro ALU_CHECK_STOP_EN: the first failure halts acceptance until clear.
module alu_result_checker #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input_1,
    input  logic [WIDTH-1:0] input_2,
    input  logic [1:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             clear,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic             mismatch,
    output logic [1:0]       ff_op,
    output logic [WIDTH-1:0] ff_expected,
    output logic [WIDTH-1:0] ff_actual,
    output logic             halted
);

    typedef enum logic { ST_RUN = 1'b0, ST_HALT = 1'b1 } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q;
    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic [1:0]       s1_op_q;
    logic [WIDTH-1:0] s1_res_q;

    logic             s2_valid_q;
    logic             s2_fail_q;
    logic [1:0]       s2_op_q;
    logic [WIDTH-1:0] s2_exp_q;
    logic [WIDTH-1:0] s2_act_q;

    logic [CNT_W-1:0] pass_q;
    logic [CNT_W-1:0] fail_q;
    logic             mismatch_q;
    logic [1:0]       ff_op_q;
    logic [WIDTH-1:0] ff_exp_q;
    logic [WIDTH-1:0] ff_act_q;

    logic             accept;
    logic [WIDTH-1:0] exp_d;
    logic             stop_on_fail;

`ifdef ALU_CHECK_STOP_EN
    assign stop_on_fail = 1'b1;
`else
    assign stop_on_fail = 1'b0;
`endif

    assign in_ready = (state_q == ST_RUN);
    assign halted   = (state_q == ST_HALT);
    assign accept   = in_valid & in_ready;

    // Arithmetic wraps modulo 2^WIDTH; carry and borrow are intentionally dropped.
    always_comb begin
        exp_d = '0;
        case (s1_op_q)
            2'b00:   exp_d = s1_a_q + s1_b_q;
            2'b01:   exp_d = s1_a_q - s1_b_q;
            2'b10:   exp_d = s1_a_q & s1_b_q;
            default: exp_d = s1_a_q | s1_b_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= '0;
            s1_res_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_fail_q  <= 1'b0;
            s2_op_q    <= '0;
            s2_exp_q   <= '0;
            s2_act_q   <= '0;
            pass_q     <= '0;
            fail_q     <= '0;
            mismatch_q <= 1'b0;
            ff_op_q    <= '0;
            ff_exp_q   <= '0;
            ff_act_q   <= '0;
        end else if (clear) begin
            // Anything accepted or retiring in this cycle is dropped.
            state_q    <= ST_RUN;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            pass_q     <= '0;
            fail_q     <= '0;
            mismatch_q <= 1'b0;
            ff_op_q    <= '0;
            ff_exp_q   <= '0;
            ff_act_q   <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_a_q   <= input_1;
                s1_b_q   <= input_2;
                s1_op_q  <= alu_control;
                s1_res_q <= alu_result;
            end

            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_fail_q <= (exp_d != s1_res_q);
                s2_op_q   <= s1_op_q;
                s2_exp_q  <= exp_d;
                s2_act_q  <= s1_res_q;
            end

            if (s2_valid_q) begin
                if (s2_fail_q) begin
                    if (fail_q != CNT_MAX) fail_q <= fail_q + 1'b1;
                    if (!mismatch_q) begin
                        mismatch_q <= 1'b1;
                        ff_op_q    <= s2_op_q;
                        ff_exp_q   <= s2_exp_q;
                        ff_act_q   <= s2_act_q;
                    end
                    if (stop_on_fail) state_q <= ST_HALT;
                end else if (pass_q != CNT_MAX) begin
                    pass_q <= pass_q + 1'b1;
                end
            end
        end
    end

    assign pass_count  = pass_q;
    assign fail_count  = fail_q;
    assign mismatch    = mismatch_q;
    assign ff_op       = ff_op_q;
    assign ff_expected = ff_exp_q;
    assign ff_actual   = ff_act_q;

endmodule

// File: tb/tb_alu_result_checker.sv
// tb/tb_alu_result_checker.sv - directed self-checking bench for alu_result_checker (WIDTH=32, CNT_W=4).
module tb_alu_result_checker;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] input_1;
    logic [WIDTH-1:0] input_2;
    logic [1:0]       alu_control;
    logic [WIDTH-1:0] alu_result;
    logic             clear;
    logic [CNT_W-1:0] pass_count;
    logic [CNT_W-1:0] fail_count;
    logic             mismatch;
    logic [1:0]       ff_op;
    logic [WIDTH-1:0] ff_expected;
    logic [WIDTH-1:0] ff_actual;
    logic             halted;

    int checks = 0;
    int errors = 0;

    alu_result_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .input_1(input_1), .input_2(input_2), .alu_control(alu_control),
        .alu_result(alu_result), .clear(clear), .pass_count(pass_count),
        .fail_count(fail_count), .mismatch(mismatch), .ff_op(ff_op),
        .ff_expected(ff_expected), .ff_actual(ff_actual), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] op, input logic [31:0] res);
        in_valid    = 1'b1;
        input_1     = a;
        input_2     = b;
        alu_control = op;
        alu_result  = res;
        @(negedge clk);
        in_valid    = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0;
        input_1 = '0; input_2 = '0; alu_control = '0; alu_result = '0;
        idle(2);
        check("reset_pass", 32'(pass_count), 0);
        check("reset_fail", 32'(fail_count), 0);
        check("reset_mismatch", 32'(mismatch), 0);
        check("reset_halted", 32'(halted), 0);
        check("reset_ready", 32'(in_ready), 1);
        rst_n = 1'b1;
        idle(1);

        // 1: single add pass, counted exactly two edges after accept
        send(23, 42, 2'b00, 65);
        check("t1_pass_after1", 32'(pass_count), 0);
        idle(1);
        check("t1_pass_mid", 32'(pass_count), 0);
        idle(1);
        check("t1_pass", 32'(pass_count), 1);
        check("t1_mismatch", 32'(mismatch), 0);

        // 2: sub/and/or back to back
        do_clear();
        send(23, 42, 2'b01, 32'hFFFF_FFED);
        send(23, 42, 2'b10, 2);
        send(23, 42, 2'b11, 63);
        idle(2);
        check("t2_pass", 32'(pass_count), 3);
        check("t2_fail", 32'(fail_count), 0);

        // 3: two fails, only the first is captured
        do_clear();
        send(23, 42, 2'b00, 64);
        send(23, 42, 2'b11, 0);
        idle(2);
        check("t3_fail", 32'(fail_count), 2);
        check("t3_mismatch", 32'(mismatch), 1);
        check("t3_ff_op", 32'(ff_op), 0);
        check("t3_ff_exp", ff_expected, 65);
        check("t3_ff_act", ff_actual, 64);
`ifdef ALU_CHECK_STOP_EN
        check("t3_halted", 32'(halted), 1);
`else
        check("t3_halted", 32'(halted), 0);
`endif

        // 4: fail, drain, then three more valids
        do_clear();
        send(1, 1, 2'b00, 3);
        idle(3);
        send(5, 6, 2'b10, 4);
        send(5, 6, 2'b10, 4);
        send(5, 6, 2'b10, 4);
        idle(3);
        check("t4_fail", 32'(fail_count), 1);
`ifdef ALU_CHECK_STOP_EN
        check("t4_pass", 32'(pass_count), 0);
        check("t4_halted", 32'(halted), 1);
        check("t4_ready", 32'(in_ready), 0);
`else
        check("t4_pass", 32'(pass_count), 3);
        check("t4_halted", 32'(halted), 0);
        check("t4_ready", 32'(in_ready), 1);
`endif
        do_clear();
        check("t4_clr_halted", 32'(halted), 0);
        check("t4_clr_ready", 32'(in_ready), 1);
        check("t4_clr_pass", 32'(pass_count), 0);
        check("t4_clr_fail", 32'(fail_count), 0);
        check("t4_clr_mismatch", 32'(mismatch), 0);
        check("t4_clr_ffexp", ff_expected, 0);

        // 5: saturation at 15
        for (int i = 0; i < 15; i++) send(32'hFFFF_FFFF, 1, 2'b00, 0);
        idle(2);
        check("t5_pass_max", 32'(pass_count), 15);
        send(7, 8, 2'b11, 15);
        idle(2);
        check("t5_pass_sat", 32'(pass_count), 15);
        check("t5_fail", 32'(fail_count), 0);

        // 6a: clear in the accept cycle drops the transaction
        do_clear();
        in_valid = 1'b1; input_1 = 2; input_2 = 3; alu_control = 2'b00; alu_result = 5;
        clear = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; clear = 1'b0;
        idle(3);
        check("t6_clr_accept", 32'(pass_count), 0);

        // 6b: clear in the retire cycle drops the transaction
        send(2, 3, 2'b00, 5);
        idle(1);
        do_clear();
        idle(2);
        check("t6_clr_retire", 32'(pass_count), 0);

        // 6c: reset with two in flight
        send(2, 3, 2'b00, 5);
        send(2, 3, 2'b00, 5);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(3);
        check("t6_rst_pass", 32'(pass_count), 0);
        check("t6_rst_fail", 32'(fail_count), 0);
        check("t6_rst_ready", 32'(in_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
